// File: rtl/neo_pixel_receiver.sv
`default_nettype none
// ============================================================================
// Module   : neo_pixel_receiver
// Function : Recovers GRB pixel words from a WS2812-style serial stream by
//            measuring high-pulse widths and detecting the latch gap.
// Revision : 1.0 - initial release
// ============================================================================
module neo_pixel_receiver #(
    parameter int NUM_PIXELS   = 5,
    parameter int THRESHOLD    = 26,
    parameter int MIN_HIGH     = 8,
    parameter int MAX_HIGH     = 50,
    parameter int LATCH_CYCLES = 2500
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       neo_data,
    output logic       pixel_valid,
    output logic [2:0] pixel_index,
    output logic [7:0] green,
    output logic [7:0] red,
    output logic [7:0] blue,
    output logic       frame_done,
    output logic [3:0] pixel_count,
    output logic       frame_error,
    output logic       receiving
);

    localparam int c_hc_w = $clog2(MAX_HIGH + 2);
    localparam int c_lc_w = $clog2(LATCH_CYCLES + 1);

    localparam logic [c_hc_w-1:0] c_hc_sat     = '1;
    localparam logic [c_hc_w-1:0] c_threshold  = c_hc_w'(THRESHOLD);
    localparam logic [c_hc_w-1:0] c_min_high   = c_hc_w'(MIN_HIGH);
    localparam logic [c_hc_w-1:0] c_max_high   = c_hc_w'(MAX_HIGH);
    localparam logic [c_lc_w-1:0] c_latch      = c_lc_w'(LATCH_CYCLES);
    localparam logic [3:0]        c_num_pixels = 4'(NUM_PIXELS);

    typedef enum logic [1:0] {
        WAIT_LATCH = 2'd0,
        IDLE       = 2'd1,
        HIGH_PHASE = 2'd2,
        LOW_PHASE  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_meta;
    logic                r_s;
    logic                r_s_d;
    logic [c_hc_w-1:0]   r_high_count;
    logic [c_lc_w-1:0]   r_low_count;
    logic [4:0]          r_bit_count;
    logic [3:0]          r_pix;
    logic [22:0]         r_sr;
    logic                r_pixel_valid;
    logic [2:0]          r_pixel_index;
    logic [7:0]          r_green;
    logic [7:0]          r_red;
    logic [7:0]          r_blue;
    logic                r_frame_done;
    logic [3:0]          r_pixel_count;
    logic                r_frame_error;

    logic                w_rise;
    logic                w_fall;
    logic                w_bit;
    logic [23:0]         w_sr_next;

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_s    <= 1'b0;
            r_s_d  <= 1'b0;
        end else begin
            r_meta <= neo_data;
            r_s    <= r_meta;
            r_s_d  <= r_s;
        end
    end

    assign w_rise    = r_s & ~r_s_d;
    assign w_fall    = ~r_s & r_s_d;
    assign w_bit     = (r_high_count >= c_threshold);
    assign w_sr_next = {r_sr, w_bit};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= WAIT_LATCH;
            r_high_count  <= '0;
            r_low_count   <= '0;
            r_bit_count   <= '0;
            r_pix         <= '0;
            r_sr          <= '0;
            r_pixel_valid <= 1'b0;
            r_pixel_index <= '0;
            r_green       <= '0;
            r_red         <= '0;
            r_blue        <= '0;
            r_frame_done  <= 1'b0;
            r_pixel_count <= '0;
            r_frame_error <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            case (r_state)
                WAIT_LATCH: begin
                    if (r_s) begin
                        r_low_count <= '0;
                    end else if (r_low_count >= c_latch) begin
                        r_state     <= IDLE;
                        r_bit_count <= '0;
                        r_pix       <= '0;
                    end else begin
                        r_low_count <= r_low_count + 1'b1;
                    end
                end
                IDLE: begin
                    if (w_rise) begin
                        r_frame_error <= 1'b0;
                        r_high_count  <= c_hc_w'(1);
                        r_state       <= HIGH_PHASE;
                    end
                end
                HIGH_PHASE: begin
                    if (r_high_count > c_max_high) begin
                        r_frame_error <= 1'b1;
                        r_low_count   <= '0;
                        r_state       <= WAIT_LATCH;
                    end else if (w_fall) begin
                        if (r_high_count < c_min_high) begin
                            r_frame_error <= 1'b1;
                            r_low_count   <= '0;
                            r_state       <= WAIT_LATCH;
                        end else begin
                            r_sr        <= w_sr_next[22:0];
                            r_low_count <= '0;
                            r_state     <= LOW_PHASE;
                            if (r_bit_count == 5'd23) begin
                                r_bit_count <= '0;
                                // Pixels past the frame length are counted as errors, not reported
                                if (r_pix < c_num_pixels) begin
                                    r_pixel_valid <= 1'b1;
                                    r_pixel_index <= r_pix[2:0];
                                    r_green       <= w_sr_next[23:16];
                                    r_red         <= w_sr_next[15:8];
                                    r_blue        <= w_sr_next[7:0];
                                    r_pix         <= r_pix + 1'b1;
                                end else begin
                                    r_frame_error <= 1'b1;
                                end
                            end else begin
                                r_bit_count <= r_bit_count + 1'b1;
                            end
                        end
                    end else if (r_s && (r_high_count != c_hc_sat)) begin
                        r_high_count <= r_high_count + 1'b1;
                    end
                end
                LOW_PHASE: begin
                    if (w_rise) begin
                        r_high_count <= c_hc_w'(1);
                        r_state      <= HIGH_PHASE;
                    end else if (r_low_count >= c_latch) begin
                        r_frame_done  <= 1'b1;
                        r_pixel_count <= r_pix;
                        if (r_bit_count != 5'd0) begin
                            r_frame_error <= 1'b1;
                        end
                        r_bit_count <= '0;
                        r_pix       <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_low_count <= r_low_count + 1'b1;
                    end
                end
                default: r_state <= WAIT_LATCH;
            endcase
        end
    end

    assign pixel_valid = r_pixel_valid;
    assign pixel_index = r_pixel_index;
    assign green       = r_green;
    assign red         = r_red;
    assign blue        = r_blue;
    assign frame_done  = r_frame_done;
    assign pixel_count = r_pixel_count;
    assign frame_error = r_frame_error;
    assign receiving   = (r_state == HIGH_PHASE) || (r_state == LOW_PHASE);

endmodule
`default_nettype wire

// File: tb/tb_neo_pixel_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_neo_pixel_receiver
// Function : Directed bench for neo_pixel_receiver with a pixel/frame scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neo_pixel_receiver;

    localparam int c_t0h    = 18;
    localparam int c_t1h    = 35;
    localparam int c_period = 62;
    localparam int c_gap    = 2600;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       neo_data = 1'b0;
    logic       pixel_valid;
    logic [2:0] pixel_index;
    logic [7:0] green;
    logic [7:0] red;
    logic [7:0] blue;
    logic       frame_done;
    logic [3:0] pixel_count;
    logic       frame_error;
    logic       receiving;

    typedef struct {
        logic [2:0] idx;
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pix_t;

    typedef struct {
        logic [3:0] cnt;
        logic       err;
    } frm_t;

    pix_t exp_pix[$];
    frm_t exp_frm[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #10 clock = ~clock;

    neo_pixel_receiver dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .neo_data    (neo_data),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .green       (green),
        .red         (red),
        .blue        (blue),
        .frame_done  (frame_done),
        .pixel_count (pixel_count),
        .frame_error (frame_error),
        .receiving   (receiving)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_pix(input int idx, input logic [23:0] grb);
        pix_t p;
        p.idx = 3'(idx);
        p.g   = grb[23:16];
        p.r   = grb[15:8];
        p.b   = grb[7:0];
        exp_pix.push_back(p);
    endtask

    task automatic expect_frame(input int cnt, input logic err);
        frm_t f;
        f.cnt = 4'(cnt);
        f.err = err;
        exp_frm.push_back(f);
    endtask

    task automatic send_bit(input int w);
        neo_data = 1'b1;
        repeat (w) @(negedge clock);
        neo_data = 1'b0;
        repeat (c_period - w) @(negedge clock);
    endtask

    task automatic send_word(input logic [23:0] v, input int nbits, input int w0, input int w1);
        for (int i = 0; i < nbits; i++) begin
            send_bit(v[23-i] ? w1 : w0);
        end
    endtask

    task automatic latch_gap();
        neo_data = 1'b0;
        repeat (c_gap) @(negedge clock);
        chk("pixel_queue_drained", exp_pix.size(), 0);
        chk("frame_queue_drained", exp_frm.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string where);
        chk({where, "_pixel_valid"}, pixel_valid, 0);
        chk({where, "_pixel_index"}, pixel_index, 0);
        chk({where, "_green"}, green, 0);
        chk({where, "_red"}, red, 0);
        chk({where, "_blue"}, blue, 0);
        chk({where, "_frame_done"}, frame_done, 0);
        chk({where, "_pixel_count"}, pixel_count, 0);
        chk({where, "_frame_error"}, frame_error, 0);
        chk({where, "_receiving"}, receiving, 0);
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expectation
    always @(negedge clock) begin : monitor
        pix_t p;
        frm_t f;
        if (pixel_valid) begin
            chk("pixel_expected", exp_pix.size() > 0, 1);
            if (exp_pix.size() > 0) begin
                p = exp_pix.pop_front();
                chk("pixel_index", pixel_index, p.idx);
                chk("green", green, p.g);
                chk("red", red, p.r);
                chk("blue", blue, p.b);
            end
        end
        if (frame_done) begin
            chk("pv_fd_exclusive", pixel_valid, 0);
            chk("frame_expected", exp_frm.size() > 0, 1);
            if (exp_frm.size() > 0) begin
                f = exp_frm.pop_front();
                chk("pixel_count", pixel_count, f.cnt);
                chk("frame_error_at_done", frame_error, f.err);
            end
        end
    end

    initial begin : watchdog
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        latch_gap();
        chk("idle_receiving", receiving, 0);

        // Single pixel
        expect_pix(0, 24'hFF00A5);
        expect_frame(1, 1'b0);
        send_word(24'hFF00A5, 24, c_t0h, c_t1h);
        latch_gap();

        // Full frame
        for (int i = 0; i < 5; i++) begin
            expect_pix(i, {8'(i), 8'(8'h10 + i), 8'(8'h80 | i)});
        end
        expect_frame(5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send_word({8'(i), 8'(8'h10 + i), 8'(8'h80 | i)}, 24, c_t0h, c_t1h);
        end
        latch_gap();

        // Threshold boundary: 25 decodes as 0, 26 as 1
        expect_pix(0, 24'h5AC30F);
        expect_frame(1, 1'b0);
        send_word(24'h5AC30F, 24, 25, 26);
        latch_gap();

        // Glitch pulse: error, bits ignored until a new latch gap
        send_bit(7);
        chk("glitch_error", frame_error, 1);
        chk("glitch_receiving", receiving, 0);
        send_word(24'h123456, 24, c_t0h, c_t1h);
        latch_gap();
        chk("glitch_error_sticky", frame_error, 1);

        expect_pix(0, 24'h112233);
        expect_frame(1, 1'b0);
        send_word(24'h112233, 1, c_t0h, c_t1h);
        chk("first_rise_clears_error", frame_error, 0);
        chk("receiving_in_frame", receiving, 1);
        send_word(24'h112233 << 1, 23, c_t0h, c_t1h);
        latch_gap();

        // Stuck-high pulse
        send_bit(51);
        chk("stuck_error", frame_error, 1);
        chk("stuck_receiving", receiving, 0);
        send_word(24'h654321, 24, c_t0h, c_t1h);
        latch_gap();
        chk("stuck_error_sticky", frame_error, 1);

        // Overflow: sixth pixel is not reported
        for (int i = 0; i < 5; i++) begin
            expect_pix(i, {8'(i * 3), 8'(~i), 8'(8'h40 + i)});
        end
        expect_frame(5, 1'b1);
        for (int i = 0; i < 6; i++) begin
            send_word({8'(i * 3), 8'(~i), 8'(8'h40 + i)}, 24, c_t0h, c_t1h);
        end
        latch_gap();

        // Partial pixel: 30 bits
        expect_pix(0, 24'hE1D2C3);
        expect_frame(1, 1'b1);
        send_word(24'hE1D2C3, 24, c_t0h, c_t1h);
        send_word(24'hAC0000, 6, c_t0h, c_t1h);
        latch_gap();
        chk("partial_error_held", frame_error, 1);

        expect_pix(0, 24'h3CC399);
        expect_frame(1, 1'b0);
        send_word(24'h3CC399, 1, c_t0h, c_t1h);
        chk("next_frame_clears_error", frame_error, 0);
        send_word(24'h3CC399 << 1, 23, c_t0h, c_t1h);
        latch_gap();

        // Reset during the 12th bit
        send_word(24'hF0F0F0, 11, c_t0h, c_t1h);
        neo_data = 1'b1;
        repeat (10) @(negedge clock);
        chk("pre_reset_receiving", receiving, 1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        neo_data = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        send_word(24'h777777, 24, c_t0h, c_t1h);
        latch_gap();
        chk("post_reset_receiving", receiving, 0);

        expect_pix(0, 24'h0FF001);
        expect_frame(1, 1'b0);
        send_word(24'h0FF001, 24, c_t0h, c_t1h);
        latch_gap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
